// File: rtl/dram_stream_reader_if.sv
// DRAM read port plus outgoing pixel stream for dram_stream_reader.
// master: the reader (drives address/strobe and stream data/valid).
// slave:  the DRAM + consumer side (drives read data and ready).
interface dram_stream_reader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output mem_addr, mem_read, m_data, m_valid,
    input  mem_dout, m_ready
  );

  modport slave (
    input  mem_addr, mem_read, m_data, m_valid,
    output mem_dout, m_ready
  );
endinterface

// File: rtl/dram_stream_reader.sv
// Sequential DRAM read initiator feeding a valid/ready pixel stream.
// Issues single-byte reads, absorbs the one-cycle DRAM latency and buffers
// returning bytes in a 2-entry skid FIFO. Reads are only issued when a FIFO
// slot is guaranteed, so backpressure never drops data.
// Optional build macro STRIDE_EN adds a 'stride' port (address increment per
// read); without it the increment is fixed at 1.
module dram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  dram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] incr;
  logic                  pop, push, rd;
  logic [2:0]            credit;

`ifdef STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign incr = stride_q;
`else
  assign incr = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  assign pop    = (count_q != 2'd0) & bus.m_ready;
  assign push   = inflight_q;
  // Slots already claimed (buffered + in flight) after this cycle's pop.
  assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd     = (state_q == StRun) && (issue_left_q != '0) && (credit < 3'd2);

  assign bus.mem_read = rd;
  assign bus.mem_addr = addr_cnt_q;
  assign bus.m_valid  = (count_q != 2'd0);
  assign bus.m_data   = fifo_q[rd_ptr_q];
  assign busy         = busy_q;
  assign done         = done_q;

  // Next-state: read issue, FIFO push/pop and transfer FSM.
  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    inflight_d   = rd;
`ifdef STRIDE_EN
    stride_d     = stride_q;
`endif

    if (rd) begin
      addr_cnt_d   = addr_cnt_q + incr;
      issue_left_d = issue_left_q - LEN_WIDTH'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      out_left_d = out_left_q - LEN_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_cnt_d   = base_addr;
          issue_left_d = length;
          out_left_d   = length;
`ifdef STRIDE_EN
          stride_d     = stride;
`endif
          if (length == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
            busy_d  = 1'b1;
          end
        end
      end
      StRun: begin
        if (pop && (out_left_q == LEN_WIDTH'(1))) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset flushes the FIFO and drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_cnt_q   <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
`ifdef STRIDE_EN
      stride_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
`ifdef STRIDE_EN
      stride_q     <= stride_d;
`endif
    end
  end

endmodule
